spi_reg_responder: RTL and testbench



---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_edge_sync.sv | 49 ++++
 rtl/spi_reg_responder.sv | 149 ++++++++++++++
 tb/tb_spi_reg_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI responder types and command field constants
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } spi_state_t;

    localparam int          RW_BIT      = 7;
    localparam int          CMD_ADDR_W  = 3;
    localparam int          CMD_RSV_W   = RW_BIT - CMD_ADDR_W;
    localparam logic [7:0]  ID_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - 2-flop bus synchronizer with CKP/CPH decoded sample/shift strobes
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ckp,
    input  logic cph,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s,
    output logic sample_stb,
    output logic shift_stb
);

    // [0] and [1] are the synchronizer, [2] holds the previous synchronized level.
    // SS resets low so a frame already in progress at reset release is not seen as a new fall.
    logic [2:0] sck_q;
    logic [2:0] ss_q;
    logic [1:0] mosi_q;
    logic       sck_rise;
    logic       sck_fall;
    logic       lead_edge;
    logic       trail_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_q  <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            ss_q   <= {ss_q[1:0], ss};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sck_rise   = sck_q[1] & ~sck_q[2];
    assign sck_fall   = ~sck_q[1] & sck_q[2];
    assign lead_edge  = ckp ? sck_fall : sck_rise;
    assign trail_edge = ckp ? sck_rise : sck_fall;
    assign sample_stb = cph ? trail_edge : lead_edge;
    assign shift_stb  = cph ? lead_edge : trail_edge;
    assign ss_fall    = ~ss_q[1] & ss_q[2];
    assign ss_rise    = ss_q[1] & ~ss_q[2];
    assign mosi_s     = mosi_q[1];

endmodule

// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI slave register bank; SPI_RSP_AUTOINC_EN enables multi-byte auto-increment
module spi_reg_responder
    import spi_pkg::*;
#(
    parameter logic [7:0] ID_BYTE = ID_BYTE_DEF,
    parameter int         ADDR_W  = CMD_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CKP,
    input  logic              CPH,
    input  logic              SS,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [7:0]        loc_rdata,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int NREG = 1 << ADDR_W;

    logic              ss_fall;
    logic              ss_rise;
    logic              mosi_s;
    logic              sample_stb;
    logic              shift_stb;
    spi_state_t        state;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        tx_sr;
    logic [7:0]        tx_load;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              rw;
    logic [7:0]        regs [NREG];

    spi_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .ckp        (CKP),
        .cph        (CPH),
        .sck        (SCK),
        .ss         (SS),
        .mosi       (MOSI),
        .ss_fall    (ss_fall),
        .ss_rise    (ss_rise),
        .mosi_s     (mosi_s),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb)
    );

    assign rx_byte   = {rx_sr, mosi_s};
    assign cmd_addr  = {rx_sr[ADDR_W-2:0], mosi_s};
    assign next_addr = addr + 1'b1;
    assign loc_rdata = regs[loc_addr];

    // Byte queued for MISO at the next byte boundary, chosen by where the frame is.
    always_comb begin
        tx_load = ID_BYTE;
        if (state == ST_CMD)
            tx_load = rx_sr[RW_BIT-1] ? regs[cmd_addr] : 8'h00;
        else if (state == ST_DATA)
            tx_load = rw ? regs[next_addr] : 8'h00;
    end

    // CPH=0 puts the MSB on MISO at load time and skips the trailing edge that closes a byte;
    // CPH=1 holds the load until the next leading edge shifts it out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            addr     <= '0;
            rw       <= 1'b0;
            MISO     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (ss_rise) begin
                state <= ST_IDLE;
                MISO  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (ss_fall) begin
                        state   <= ST_CMD;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        if (CPH) begin
                            tx_sr <= tx_load;
                        end else begin
                            MISO  <= tx_load[7];
                            tx_sr <= {tx_load[6:0], 1'b0};
                        end
                    end
                    ST_CMD, ST_DATA: begin
                        if (sample_stb) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                if (CPH) begin
                                    tx_sr <= tx_load;
                                end else begin
                                    MISO  <= tx_load[7];
                                    tx_sr <= {tx_load[6:0], 1'b0};
                                end
                                if (state == ST_CMD) begin
                                    addr  <= cmd_addr;
                                    rw    <= rx_sr[RW_BIT-1];
                                    state <= ST_DATA;
                                end else begin
                                    if (!rw) begin
                                        regs[addr] <= rx_byte;
                                        wr_pulse   <= 1'b1;
                                        wr_addr    <= addr;
                                        wr_data    <= rx_byte;
                                    end
`ifdef SPI_RSP_AUTOINC_EN
                                    addr <= next_addr;
`else
                                    state <= ST_DRAIN;
                                    MISO  <= 1'b0;
                                    tx_sr <= '0;
`endif
                                end
                            end
                        end else if (shift_stb && (CPH || bit_cnt != 3'd0)) begin
                            MISO  <= tx_sr[7];
                            tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb/tb_spi_reg_responder.sv - directed self-checking bench for spi_reg_responder
module tb_spi_reg_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       CKP = 1'b0;
    logic       CPH = 1'b0;
    logic       SS = 1'b1;
    logic       SCK = 1'b0;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [2:0] loc_addr = '0;
    logic [7:0] loc_rdata;
    logic       wr_pulse;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;
    int p0;
    logic [7:0] r0, r1, r2;

    spi_reg_responder dut (
        .clk       (clk),
        .rst       (rst),
        .CKP       (CKP),
        .CPH       (CPH),
        .SS        (SS),
        .SCK       (SCK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_pulse) pulse_cnt <= pulse_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input logic ckp, input logic cph);
        CKP = ckp;
        CPH = cph;
        SCK = ckp;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_begin();
        SS = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_fall_lag", busy, 0);
        @(negedge clk);
        check("busy_fall", busy, 1);
        repeat (HALF - 3) @(negedge clk);
    endtask

    task automatic frame_end(input logic active);
        repeat (HALF) @(negedge clk);
        SS = 1'b1;
        repeat (2) @(negedge clk);
        if (active) check("busy_rise_lag", busy, 1);
        @(negedge clk);
        check("busy_rise", busy, 0);
        check("miso_idle", MISO, 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!CPH) begin
                MOSI = tx[i];
                repeat (HALF) @(negedge clk);
                rx[i] = MISO;
                SCK = ~SCK;
                repeat (HALF) @(negedge clk);
                SCK = ~SCK;
            end else begin
                SCK = ~SCK;
                MOSI = tx[i];
                repeat (HALF) @(negedge clk);
                rx[i] = MISO;
                SCK = ~SCK;
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_miso", MISO, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_loc_rdata", loc_rdata, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // mode 10: write 5A to reg2
        set_mode(1'b1, 1'b0);
        p0 = pulse_cnt;
        frame_begin();
        xfer(8'h02, 8, r0);
        xfer(8'h5A, 8, r1);
        frame_end(1'b1);
        check("m10_id", r0, 8'hA5);
        check("m10_wr_miso", r1, 8'h00);
        check("m10_pulses", pulse_cnt - p0, 1);
        check("m10_wr_addr", wr_addr, 2);
        check("m10_wr_data", wr_data, 8'h5A);
        loc_addr = 3'd2;
        @(negedge clk);
        check("m10_loc_rdata", loc_rdata, 8'h5A);

        // mode 01: read reg2, reserved command bits ignored
        set_mode(1'b0, 1'b1);
        p0 = pulse_cnt;
        frame_begin();
        xfer(8'h82, 8, r0);
        xfer(8'h00, 8, r1);
        frame_end(1'b1);
        check("m01_id", r0, 8'hA5);
        check("m01_read", r1, 8'h5A);
        frame_begin();
        xfer(8'hFA, 8, r0);
        xfer(8'h00, 8, r1);
        frame_end(1'b1);
        check("m01_rsv_read", r1, 8'h5A);
        check("m01_pulses", pulse_cnt - p0, 0);

        // aborted write: SS rises after 5 data bits
        set_mode(1'b0, 1'b0);
        p0 = pulse_cnt;
        frame_begin();
        xfer(8'h05, 8, r0);
        xfer(8'hFF, 5, r1);
        frame_end(1'b1);
        check("abort_pulses", pulse_cnt - p0, 0);
        loc_addr = 3'd5;
        @(negedge clk);
        check("abort_reg5", loc_rdata, 8'h00);

        // reset mid-command, then a fresh write of 33 to addr 1
        set_mode(1'b1, 1'b1);
        frame_begin();
        xfer(8'h00, 4, r0);
        rst = 1'b0;
        loc_addr = 3'd2;
        @(negedge clk);
        check("mid_rst_miso", MISO, 0);
        check("mid_rst_wr_pulse", wr_pulse, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_reg2", loc_rdata, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        p0 = pulse_cnt;
        xfer(8'h00, 4, r0);
        xfer(8'h44, 8, r1);
        frame_end(1'b0);
        check("post_rst_ignored", pulse_cnt - p0, 0);
        frame_begin();
        xfer(8'h01, 8, r0);
        xfer(8'h33, 8, r1);
        frame_end(1'b1);
        check("post_rst_pulses", pulse_cnt - p0, 1);
        check("post_rst_wr_addr", wr_addr, 1);
        check("post_rst_wr_data", wr_data, 8'h33);
        loc_addr = 3'd1;
        @(negedge clk);
        check("post_rst_reg1", loc_rdata, 8'h33);

        // three-byte write frame
        set_mode(1'b0, 1'b0);
        p0 = pulse_cnt;
        frame_begin();
        xfer(8'h07, 8, r0);
        xfer(8'h11, 8, r1);
        xfer(8'h22, 8, r2);
        frame_end(1'b1);
        loc_addr = 3'd7;
        @(negedge clk);
        check("multi_reg7", loc_rdata, 8'h11);
        loc_addr = 3'd0;
        @(negedge clk);
`ifdef SPI_RSP_AUTOINC_EN
        check("multi_reg0", loc_rdata, 8'h22);
        check("multi_pulses", pulse_cnt - p0, 2);
`else
        check("multi_reg0", loc_rdata, 8'h00);
        check("multi_pulses", pulse_cnt - p0, 1);
`endif

        // all four modes read untouched reg3
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0]);
            frame_begin();
            xfer(8'h83, 8, r0);
            xfer(8'h00, 8, r1);
            frame_end(1'b1);
            check("modes_id", r0, 8'hA5);
            check("modes_reg3", r1, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
